fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the decoder. Owns the fetch PC and issues
//  in-order requests to instruction memory over a req/gnt + rvalid interface.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited in-order
// requests to instruction memory and buffers returned words for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        INST_READY
);

  localparam int            CW       = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   QDEPTH_W = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic          req_q, req_d;
  logic          inst_valid_q, inst_valid_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] q_cnt_q, q_cnt_d;
  logic [31:0]   pcf_q [QDEPTH];
  logic [31:0]   pcf_d [QDEPTH];
  logic [31:0]   qd_q  [QDEPTH];
  logic [31:0]   qd_d  [QDEPTH];
  logic [31:0]   qp_q  [QDEPTH];
  logic [31:0]   qp_d  [QDEPTH];

  logic [31:0]   pcf_shift_s [QDEPTH];
  logic [31:0]   qd_shift_s  [QDEPTH];
  logic [31:0]   qp_shift_s  [QDEPTH];
  logic          gnt_s, pop_s, push_s;
  logic [CW-1:0] pcf_base_s, q_base_s;
  logic [31:0]   tgt_pc_s;
  logic [CW:0]   credit_s;

  // Next-state logic for fetch PC, credit, in-flight PC FIFO, queue and drain FSM.
  always_comb begin
    gnt_s    = req_q & IMEM_GNT;
    pop_s    = inst_valid_q & INST_READY;
    // A response landing in the redirect cycle is wrong-path and never enters the queue.
    push_s   = IMEM_RVALID & (state_q == ST_RUN) & ~REDIRECT;
    tgt_pc_s = REDIRECT_PC & 32'hFFFF_FFFC;

    pcf_shift_s = pcf_q;
    qd_shift_s  = qd_q;
    qp_shift_s  = qp_q;
    for (int i = 0; i < QDEPTH - 1; i++) begin
      pcf_shift_s[i] = pcf_q[i + 1];
      qd_shift_s[i]  = qd_q[i + 1];
      qp_shift_s[i]  = qp_q[i + 1];
    end

    pcf_base_s = out_cnt_q - CW'(IMEM_RVALID);
    q_base_s   = q_cnt_q - CW'(pop_s);
    for (int i = 0; i < QDEPTH; i++) begin
      pcf_d[i] = (gnt_s && (pcf_base_s == CW'(i))) ? fpc_q :
                 (IMEM_RVALID ? pcf_shift_s[i] : pcf_q[i]);
      qd_d[i]  = (push_s && (q_base_s == CW'(i))) ? IMEM_RDATA :
                 (pop_s ? qd_shift_s[i] : qd_q[i]);
      qp_d[i]  = (push_s && (q_base_s == CW'(i))) ? pcf_q[0] :
                 (pop_s ? qp_shift_s[i] : qp_q[i]);
    end

    out_cnt_d    = pcf_base_s + CW'(gnt_s);
    q_cnt_d      = REDIRECT ? CNT_ZERO : (q_base_s + CW'(push_s));
    inst_valid_d = (q_cnt_d != CNT_ZERO);

    if (REDIRECT) begin
      fpc_d = tgt_pc_s;
    end else if (gnt_s) begin
      fpc_d = fpc_q + 32'd4;
    end else begin
      fpc_d = fpc_q;
    end

    // Every request still in flight after a redirect (including one granted now) is wrong-path.
    if (REDIRECT) begin
      drop_cnt_d = out_cnt_d;
      state_d    = (out_cnt_d != CNT_ZERO) ? ST_DRAIN : ST_RUN;
    end else if (IMEM_RVALID && (state_q == ST_DRAIN)) begin
      drop_cnt_d = drop_cnt_q - CW'(1'b1);
      state_d    = (drop_cnt_d == CNT_ZERO) ? ST_RUN : ST_DRAIN;
    end else begin
      drop_cnt_d = drop_cnt_q;
      state_d    = state_q;
    end

    credit_s = {1'b0, out_cnt_d} + {1'b0, q_cnt_d};
    req_d    = (credit_s < QDEPTH_W);
  end

  // State registers; async reset returns to an empty queue fetching from RESET_PC.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_RUN;
      fpc_q        <= RESET_PC;
      req_q        <= 1'b0;
      inst_valid_q <= 1'b0;
      out_cnt_q    <= CNT_ZERO;
      drop_cnt_q   <= CNT_ZERO;
      q_cnt_q      <= CNT_ZERO;
      for (int i = 0; i < QDEPTH; i++) begin
        pcf_q[i] <= 32'h0;
        qd_q[i]  <= 32'h0;
        qp_q[i]  <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      req_q        <= req_d;
      inst_valid_q <= inst_valid_d;
      out_cnt_q    <= out_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      q_cnt_q      <= q_cnt_d;
      pcf_q        <= pcf_d;
      qd_q         <= qd_d;
      qp_q         <= qp_d;
    end
  end

  assign IMEM_REQ   = req_q;
  assign IMEM_ADDR  = fpc_q;
  assign INST_VALID = inst_valid_q;
  assign INST       = qd_q[0];
  assign INST_PC    = qp_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory plus an architectural
// PC-stream scoreboard, directed scenarios and a randomized phase.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        INST_VALID;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_READY = 1'b0;

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .INST_VALID(INST_VALID), .INST(INST), .INST_PC(INST_PC), .INST_READY(INST_READY)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int delivered = 0;
  int gnt_pct = 100;
  int rv_pct = 100;
  int lat_max = 0;
  bit hold_resp = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  bit          prev_hold = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C} + 32'h1357_9BDF;
  endfunction

  // Memory presents GNT/RVALID for the cycle just started.
  task automatic drive_mem();
    IMEM_GNT = IMEM_REQ && ($urandom_range(99) < gnt_pct);
    if (pend_addr.size() > 0 && !hold_resp && pend_rdy[0] <= cyc &&
        $urandom_range(99) < rv_pct) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = mem_word(pend_addr[0]);
    end else begin
      IMEM_RVALID = 1'b0;
      IMEM_RDATA  = $urandom;
    end
  endtask

  // Observe the settled cycle: memory bookkeeping, address hold and the PC-stream scoreboard.
  task automatic record();
    if (prev_hold && !prev_redir) begin
      check_eq("req_held", 32'(IMEM_REQ), 32'h1);
      check_eq("addr_held", IMEM_ADDR, prev_addr);
    end
    if (IMEM_REQ && IMEM_GNT) begin
      check_eq("addr_align", IMEM_ADDR & 32'h3, 32'h0);
      pend_addr.push_back(IMEM_ADDR);
      pend_rdy.push_back(cyc + 1 + int'($urandom_range(lat_max)));
      check_eq("credit", 32'(pend_addr.size() <= QDEPTH), 32'h1);
    end
    if (IMEM_RVALID) begin
      void'(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end
    if (INST_VALID && INST_READY) begin
      check_eq("inst_pc", INST_PC, exp_pc);
      check_eq("inst_word", INST, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (REDIRECT) exp_pc = REDIRECT_PC & 32'hFFFF_FFFC;
    prev_hold  = IMEM_REQ && !IMEM_GNT;
    prev_redir = REDIRECT;
    prev_addr  = IMEM_ADDR;
  endtask

  task automatic tick();
    @(negedge CLK);
    record();
    @(posedge CLK);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    IMEM_GNT = 1'b0;
    IMEM_RVALID = 1'b0;
    REDIRECT = 1'b0;
    pend_addr.delete();
    pend_rdy.delete();
    exp_pc = RESET_PC;
    prev_hold = 1'b0;
    repeat (3) tick();
    RSTN = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    REDIRECT = 1'b1;
    REDIRECT_PC = pc;
    tick();
    REDIRECT = 1'b0;
  endtask

  initial begin
    int base;
    bit found;
    logic [31:0] tgt;

    // Reset values and first request.
    #1;
    do_reset();
    RSTN = 1'b0;
    #1;
    check_eq("rst_req", 32'(IMEM_REQ), 32'h0);
    check_eq("rst_addr", IMEM_ADDR, RESET_PC);
    check_eq("rst_valid", 32'(INST_VALID), 32'h0);
    check_eq("rst_inst", INST, 32'h0);
    check_eq("rst_pc", INST_PC, 32'h0);
    RSTN = 1'b1;
    #2;
    check_eq("req_pre_edge", 32'(IMEM_REQ), 32'h0);
    INST_READY = 1'b1;
    tick();
    check_eq("req_rise", 32'(IMEM_REQ), 32'h1);

    // Streaming with single-cycle memory.
    repeat (30) tick();
    check_eq("stream_count", 32'(delivered >= 15), 32'h1);

    // Decode stalled: queue fills, requests stop, then drains in order.
    INST_READY = 1'b0;
    do_reset();
    repeat (12) tick();
    check_eq("stall_valid", 32'(INST_VALID), 32'h1);
    check_eq("stall_head_pc", INST_PC, RESET_PC);
    check_eq("stall_req_low", 32'(IMEM_REQ), 32'h0);
    check_eq("stall_no_outst", 32'(pend_addr.size()), 32'h0);
    base = delivered;
    INST_READY = 1'b1;
    for (int n = 0; n < 20 && delivered < base + 2; n++) tick();
    check_eq("stall_drained", 32'(delivered >= base + 2), 32'h1);
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      found = IMEM_REQ;
      if (!found) tick();
    end
    check_eq("stall_req_resume", 32'(found), 32'h1);

    // Two requests outstanding, then redirect: both responses dropped.
    do_reset();
    hold_resp = 1'b1;
    for (int n = 0; n < 10 && pend_addr.size() < 2; n++) tick();
    tick();
    check_eq("outst_two", 32'(pend_addr.size()), 32'h2);
    check_eq("outst_req_low", 32'(IMEM_REQ), 32'h0);
    pulse_redirect(32'h0000_0074);
    check_eq("redir_addr", IMEM_ADDR, 32'h0000_0074);
    check_eq("redir_flush", 32'(INST_VALID), 32'h0);
    hold_resp = 1'b0;
    base = delivered;
    for (int n = 0; n < 30 && delivered < base + 2; n++) tick();
    check_eq("redir_resume", 32'(delivered >= base + 2), 32'h1);

    // Redirect in the same cycle as a response and a grant.
    do_reset();
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (IMEM_GNT && IMEM_RVALID) begin
        found = 1'b1;
        pulse_redirect(32'h0000_0200);
      end else begin
        tick();
      end
    end
    check_eq("rv_gnt_redir_seen", 32'(found), 32'h1);
    base = delivered;
    repeat (20) tick();
    check_eq("rv_gnt_resume", 32'(delivered > base), 32'h1);

    // Redirect while a request waits for grant; misaligned target is aligned down.
    gnt_pct = 0;
    do_reset();
    for (int n = 0; n < 10 && !IMEM_REQ; n++) tick();
    tick();
    pulse_redirect(32'h0000_0123);
    check_eq("retarget_addr", IMEM_ADDR, 32'h0000_0120);
    check_eq("retarget_req", 32'(IMEM_REQ), 32'h1);
    gnt_pct = 100;
    base = delivered;
    repeat (10) tick();
    check_eq("retarget_resume", 32'(delivered > base), 32'h1);

    // Asynchronous reset in mid-stream.
    for (int n = 0; n < 10 && !INST_VALID; n++) tick();
    check_eq("async_pre_valid", 32'(INST_VALID), 32'h1);
    #2;
    RSTN = 1'b0;
    #1;
    check_eq("async_valid", 32'(INST_VALID), 32'h0);
    check_eq("async_req", 32'(IMEM_REQ), 32'h0);
    check_eq("async_addr", IMEM_ADDR, RESET_PC);
    do_reset();
    base = delivered;
    repeat (15) tick();
    check_eq("async_restart", 32'(delivered > base), 32'h1);

    // Randomized traffic against the PC-stream scoreboard.
    gnt_pct = 75;
    rv_pct = 65;
    lat_max = 2;
    do_reset();
    base = delivered;
    for (int n = 0; n < 3000; n++) begin
      INST_READY = ($urandom_range(99) < 70);
      if (!REDIRECT && $urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0:       tgt = 32'hFFFF_FFF6;
          default: tgt = $urandom & 32'h0000_FFFF;
        endcase
        REDIRECT = 1'b1;
        REDIRECT_PC = tgt;
      end else begin
        REDIRECT = 1'b0;
      end
      tick();
    end
    REDIRECT = 1'b0;
    INST_READY = 1'b1;
    repeat (20) tick();
    check_eq("random_progress", 32'(delivered > base + 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
